// File: rtl/mem_stage.sv
// mem_stage: LC-3b MEM stage, runs data-cache accesses and loads the MEM/WB latch.
// Optional build macro MEM_ALIGN_TRAP_EN: odd-address word accesses fault instead of masking bit 0.
module mem_stage #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic [15:0] mem_ir,
    input  logic [15:0] mem_npc,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_aluresult,
    input  logic [15:0] mem_srcdata,
    input  logic [2:0]  mem_drid,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    input  logic        mem_indirect,
    input  logic        mem_byte,
    input  logic        mem_load_reg,
    output logic        mem_stall,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [15:0] dmem_address,
    output logic [15:0] dmem_wdata,
    output logic [1:0]  dmem_byte_enable,
    input  logic        dmem_resp,
    input  logic [15:0] dmem_rdata,
    output logic        wb_valid,
    output logic [15:0] wb_result,
    output logic [15:0] wb_npc,
    output logic [15:0] wb_ir,
    output logic [2:0]  wb_drid,
    output logic        wb_load_reg,
    output logic        wb_fault
);
    typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

    localparam logic        WD_EN     = (MAX_WAIT != 0);
    localparam logic [15:0] WAIT_LAST = (MAX_WAIT == 0) ? 16'd0 : 16'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [15:0] wait_q, wait_d;
    logic [15:0] ptr_q, ptr_d;
    logic [15:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;

    logic [15:0] ir_q, npc_q, addr_q, alu_q, src_q;
    logic [2:0]  drid_q;
    logic        wr_q, ind_q, byte_q, ldreg_q;

    logic        wb_valid_q, wb_valid_d;
    logic [15:0] wb_result_q, wb_result_d;
    logic [15:0] wb_npc_q, wb_npc_d;
    logic [15:0] wb_ir_q, wb_ir_d;
    logic [2:0]  wb_drid_q, wb_drid_d;
    logic        wb_load_reg_q, wb_load_reg_d;
    logic        wb_fault_q, wb_fault_d;

    logic        is_mem, capture, timeout, byte_acc, trap_idle, trap_ptr;
    logic [7:0]  sel_byte;
    logic [15:0] load_val;

    assign is_mem   = mem_valid & (mem_read_en | mem_write_en);
    assign capture  = (state_q == IDLE) & is_mem;
    assign timeout  = WD_EN & ~dmem_resp & (wait_q == WAIT_LAST);
    assign byte_acc = byte_q & ~ind_q;
    assign sel_byte = addr_q[0] ? rdata_q[15:8] : rdata_q[7:0];
    assign load_val = byte_q ? {{8{sel_byte[7]}}, sel_byte} : rdata_q;

`ifdef MEM_ALIGN_TRAP_EN
    assign trap_idle = ~mem_indirect & ~mem_byte & mem_address[0];
    assign trap_ptr  = dmem_rdata[0];
`else
    assign trap_idle = 1'b0;
    assign trap_ptr  = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        wait_d           = wait_q;
        ptr_d            = ptr_q;
        rdata_d          = rdata_q;
        fault_d          = fault_q;
        wb_valid_d       = wb_valid_q;
        wb_result_d      = wb_result_q;
        wb_npc_d         = wb_npc_q;
        wb_ir_d          = wb_ir_q;
        wb_drid_d        = wb_drid_q;
        wb_load_reg_d    = wb_load_reg_q;
        wb_fault_d       = wb_fault_q;
        mem_stall        = 1'b0;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = 16'd0;
        dmem_wdata       = 16'd0;
        dmem_byte_enable = 2'b00;

        case (state_q)
            IDLE: begin
                mem_stall = is_mem;
                if (!mem_valid) begin
                    wb_valid_d = 1'b0;
                end else if (!is_mem) begin
                    wb_valid_d    = 1'b1;
                    wb_result_d   = mem_aluresult;
                    wb_npc_d      = mem_npc;
                    wb_ir_d       = mem_ir;
                    wb_drid_d     = mem_drid;
                    wb_load_reg_d = mem_load_reg;
                    wb_fault_d    = 1'b0;
                end else begin
                    wb_valid_d = 1'b0;
                    wait_d     = 16'd0;
                    fault_d    = trap_idle;
                    state_d    = trap_idle ? DONE : ACC1;
                end
            end
            ACC1: begin
                mem_stall        = 1'b1;
                dmem_read        = ind_q | ~wr_q;
                dmem_write       = wr_q & ~ind_q;
                dmem_address     = byte_acc ? addr_q : {addr_q[15:1], 1'b0};
                dmem_wdata       = byte_acc ? {src_q[7:0], src_q[7:0]} : src_q;
                dmem_byte_enable = byte_acc ? (addr_q[0] ? 2'b10 : 2'b01) : 2'b11;
                wait_d           = wait_q + 16'd1;
                if (dmem_resp) begin
                    if (ind_q) begin
                        // Pointer fetched; the second access restarts the watchdog.
                        ptr_d  = dmem_rdata;
                        wait_d = 16'd0;
                        if (trap_ptr) begin
                            fault_d = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = ACC2;
                        end
                    end else begin
                        rdata_d = dmem_rdata;
                        state_d = DONE;
                    end
                end else if (timeout) begin
                    fault_d = 1'b1;
                    state_d = DONE;
                end
            end
            ACC2: begin
                mem_stall        = 1'b1;
                dmem_read        = ~wr_q;
                dmem_write       = wr_q;
                dmem_address     = {ptr_q[15:1], 1'b0};
                dmem_wdata       = src_q;
                dmem_byte_enable = 2'b11;
                wait_d           = wait_q + 16'd1;
                if (dmem_resp) begin
                    rdata_d = dmem_rdata;
                    state_d = DONE;
                end else if (timeout) begin
                    fault_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Stall released here so the EX/MEM latch advances on this same edge.
                wb_valid_d    = 1'b1;
                wb_result_d   = (wr_q | fault_q) ? alu_q : load_val;
                wb_npc_d      = npc_q;
                wb_ir_d       = ir_q;
                wb_drid_d     = drid_q;
                wb_load_reg_d = ldreg_q & ~fault_q;
                wb_fault_d    = fault_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wait_q        <= 16'd0;
            ptr_q         <= 16'd0;
            rdata_q       <= 16'd0;
            fault_q       <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_result_q   <= 16'd0;
            wb_npc_q      <= 16'd0;
            wb_ir_q       <= 16'd0;
            wb_drid_q     <= 3'd0;
            wb_load_reg_q <= 1'b0;
            wb_fault_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            ptr_q         <= ptr_d;
            rdata_q       <= rdata_d;
            fault_q       <= fault_d;
            wb_valid_q    <= wb_valid_d;
            wb_result_q   <= wb_result_d;
            wb_npc_q      <= wb_npc_d;
            wb_ir_q       <= wb_ir_d;
            wb_drid_q     <= wb_drid_d;
            wb_load_reg_q <= wb_load_reg_d;
            wb_fault_q    <= wb_fault_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q    <= 16'd0;
            npc_q   <= 16'd0;
            addr_q  <= 16'd0;
            alu_q   <= 16'd0;
            src_q   <= 16'd0;
            drid_q  <= 3'd0;
            wr_q    <= 1'b0;
            ind_q   <= 1'b0;
            byte_q  <= 1'b0;
            ldreg_q <= 1'b0;
        end else if (capture) begin
            ir_q    <= mem_ir;
            npc_q   <= mem_npc;
            addr_q  <= mem_address;
            alu_q   <= mem_aluresult;
            src_q   <= mem_srcdata;
            drid_q  <= mem_drid;
            wr_q    <= mem_write_en;
            ind_q   <= mem_indirect;
            byte_q  <= mem_byte;
            ldreg_q <= mem_load_reg;
        end
    end

    assign wb_valid    = wb_valid_q;
    assign wb_result   = wb_result_q;
    assign wb_npc      = wb_npc_q;
    assign wb_ir       = wb_ir_q;
    assign wb_drid     = wb_drid_q;
    assign wb_load_reg = wb_load_reg_q;
    assign wb_fault    = wb_fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven and randomized bench for mem_stage with a word-memory reference model.
// Expectations follow the MEM_ALIGN_TRAP_EN setting of the build.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid = 1'b0;
    logic [15:0] mem_ir = '0, mem_npc = '0, mem_address = '0, mem_aluresult = '0, mem_srcdata = '0;
    logic [2:0]  mem_drid = '0;
    logic        mem_read_en = 1'b0, mem_write_en = 1'b0, mem_indirect = 1'b0, mem_byte = 1'b0;
    logic        mem_load_reg = 1'b0;
    logic        mem_stall, dmem_read, dmem_write;
    logic [15:0] dmem_address, dmem_wdata;
    logic [1:0]  dmem_byte_enable;
    logic        dmem_resp = 1'b0;
    logic [15:0] dmem_rdata = '0;
    logic        wb_valid, wb_load_reg, wb_fault;
    logic [15:0] wb_result, wb_npc, wb_ir;
    logic [2:0]  wb_drid;

`ifdef MEM_ALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    mem_stage #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_ir(mem_ir), .mem_npc(mem_npc),
        .mem_address(mem_address), .mem_aluresult(mem_aluresult), .mem_srcdata(mem_srcdata),
        .mem_drid(mem_drid), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_indirect(mem_indirect), .mem_byte(mem_byte), .mem_load_reg(mem_load_reg),
        .mem_stall(mem_stall), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_address(dmem_address), .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
        .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_result(wb_result),
        .wb_npc(wb_npc), .wb_ir(wb_ir), .wb_drid(wb_drid), .wb_load_reg(wb_load_reg), .wb_fault(wb_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr, ind, byt, ldreg;
        logic [15:0] addr, alu, src;
        logic [2:0]  drid;
        int          delay;
        logic [15:0] exp_res;
        logic        exp_flt;
    } vec_t;

    int total = 0;
    int bad = 0;
    logic [15:0] cache_m [logic [15:0]];
    logic [15:0] ref_m [logic [15:0]];
    logic [34:0] exp_q [$];
    vec_t tbl [12];

    function automatic void chk(string nm, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [15:0] cache_rd(logic [15:0] a);
        return cache_m.exists(a) ? cache_m[a] : 16'h0000;
    endfunction

    function automatic logic [15:0] ref_rd(logic [15:0] a);
        return ref_m.exists(a) ? ref_m[a] : 16'h0000;
    endfunction

    function automatic void cache_wr(logic [15:0] a, logic [15:0] d, logic [1:0] be);
        logic [15:0] wa, w;
        wa = {a[15:1], 1'b0};
        w = cache_rd(wa);
        if (be[0]) w[7:0] = d[7:0];
        if (be[1]) w[15:8] = d[15:8];
        cache_m[wa] = w;
    endfunction

    function automatic void preload(logic [15:0] a, logic [15:0] d);
        cache_m[a] = d;
        ref_m[a] = d;
    endfunction

    function automatic logic [34:0] pk(logic wr, logic [15:0] a, logic [15:0] d, logic [1:0] be);
        return {wr, a, d, be};
    endfunction

    function automatic vec_t mkv(logic rd, logic wr, logic ind, logic byt, logic ldreg, logic [15:0] addr,
                                 logic [15:0] alu, logic [15:0] src, logic [2:0] drid, int delay,
                                 logic [15:0] exp_res, logic exp_flt);
        vec_t v;
        v.rd = rd; v.wr = wr; v.ind = ind; v.byt = byt; v.ldreg = ldreg;
        v.addr = addr; v.alu = alu; v.src = src; v.drid = drid; v.delay = delay;
        v.exp_res = exp_res; v.exp_flt = exp_flt;
        return v;
    endfunction

    // Reference: expected cache requests plus architectural result, straight from the ISA rules.
    function automatic void model_exec(input vec_t v, output logic [15:0] res, output logic flt);
        logic [15:0] a, p, w;
        logic [7:0]  b;
        int          sv;
        exp_q.delete();
        flt = 1'b0;
        res = v.alu;
        if (!v.rd && !v.wr) return;
        a = v.addr & 16'hFFFE;
        if (v.ind) begin
            exp_q.push_back(pk(1'b0, a, 16'h0, 2'b11));
            p = ref_rd(a);
            if (TRAP_EN && (p % 2 == 1)) begin flt = 1'b1; return; end
            p = p & 16'hFFFE;
            if (v.wr) begin
                exp_q.push_back(pk(1'b1, p, v.src, 2'b11));
                ref_m[p] = v.src;
            end else begin
                exp_q.push_back(pk(1'b0, p, 16'h0, 2'b11));
                res = ref_rd(p);
            end
        end else if (v.byt) begin
            w = ref_rd(a);
            if (v.wr) begin
                exp_q.push_back(pk(1'b1, v.addr, {v.src[7:0], v.src[7:0]}, v.addr[0] ? 2'b10 : 2'b01));
                if (v.addr[0]) w[15:8] = v.src[7:0];
                else w[7:0] = v.src[7:0];
                ref_m[a] = w;
            end else begin
                exp_q.push_back(pk(1'b0, v.addr, 16'h0, 2'b11));
                b = v.addr[0] ? w[15:8] : w[7:0];
                sv = (b >= 8'd128) ? int'(b) - 256 : int'(b);
                res = 16'(sv);
            end
        end else begin
            if (TRAP_EN && (v.addr % 2 == 1)) begin flt = 1'b1; return; end
            if (v.wr) begin
                exp_q.push_back(pk(1'b1, a, v.src, 2'b11));
                ref_m[a] = v.src;
            end else begin
                exp_q.push_back(pk(1'b0, a, 16'h0, 2'b11));
                res = ref_rd(a);
            end
        end
    endfunction

    // Entered just after a rising edge with the stage in IDLE; leaves it the same way.
    task automatic run_vec(input vec_t v, input logic [15:0] exp_res, input logic exp_flt);
        logic [34:0] req;
        logic [15:0] ir, npc;
        ir = 16'($urandom);
        npc = 16'($urandom);
        mem_valid = 1'b1; mem_ir = ir; mem_npc = npc; mem_address = v.addr;
        mem_aluresult = v.alu; mem_srcdata = v.src; mem_drid = v.drid;
        mem_read_en = v.rd; mem_write_en = v.wr; mem_indirect = v.ind; mem_byte = v.byt;
        mem_load_reg = v.ldreg;
        @(negedge clk);
        chk("idle_noreq", {15'd0, dmem_read | dmem_write}, 16'd0);
        if (!v.rd && !v.wr) begin
            chk("alu_stall", mem_stall, 1'b0);
            @(posedge clk); #1;
            mem_valid = 1'b0;
            chk("alu_wb_valid", wb_valid, 1'b1);
            chk("alu_wb_result", wb_result, exp_res);
            chk("alu_wb_drid", wb_drid, v.drid);
            chk("alu_wb_npc", wb_npc, npc);
            chk("alu_wb_load_reg", wb_load_reg, v.ldreg);
            chk("alu_wb_fault", wb_fault, 1'b0);
            return;
        end
        chk("idle_stall", mem_stall, 1'b1);
        @(posedge clk); #1;
        while (exp_q.size() > 0) begin
            req = exp_q.pop_front();
            for (int d = 0; d <= v.delay; d++) begin
                @(negedge clk);
                chk("acc_stall", mem_stall, 1'b1);
                chk("acc_write", dmem_write, req[34]);
                chk("acc_read", dmem_read, !req[34]);
                chk("acc_addr", dmem_address, req[33:18]);
                chk("acc_wb_valid", wb_valid, 1'b0);
                if (req[34]) begin
                    chk("acc_wdata", dmem_wdata, req[17:2]);
                    chk("acc_be", {14'd0, dmem_byte_enable}, {14'd0, req[1:0]});
                end
                if (d == v.delay) begin
                    dmem_resp = 1'b1;
                    dmem_rdata = cache_rd({dmem_address[15:1], 1'b0});
                    if (dmem_write) cache_wr(dmem_address, dmem_wdata, dmem_byte_enable);
                end
                @(posedge clk); #1;
                dmem_resp = 1'b0;
                dmem_rdata = 16'($urandom);
            end
        end
        @(negedge clk);
        chk("done_stall", mem_stall, 1'b0);
        chk("done_noreq", {15'd0, dmem_read | dmem_write}, 16'd0);
        @(posedge clk); #1;
        mem_valid = 1'b0;
        chk("wb_valid", wb_valid, 1'b1);
        chk("wb_fault", wb_fault, exp_flt);
        chk("wb_load_reg", wb_load_reg, v.ldreg & !exp_flt);
        chk("wb_drid", wb_drid, v.drid);
        chk("wb_ir", wb_ir, ir);
        chk("wb_npc", wb_npc, npc);
        if (!exp_flt) chk("wb_result", wb_result, exp_res);
    endtask

    initial begin
        logic [15:0] m_res;
        logic        m_flt;
        vec_t        v;
        int          kind;

        preload(16'h4000, 16'h80FF);
        preload(16'h3000, 16'h5002);
        preload(16'h5002, 16'h7777);
        preload(16'h6000, 16'h1357);
        for (int i = 0; i < 16; i++)
            preload(16'h8000 + 16'(2 * i), 16'h8000 | 16'($urandom_range(0, 31)));

        tbl[0]  = mkv(0, 0, 0, 0, 1, 16'h0000, 16'h1234, 16'h0000, 3, 0, 16'h1234, 0);
        tbl[1]  = mkv(1, 0, 0, 1, 1, 16'h4001, 16'h4001, 16'h0000, 1, 1, 16'hFF80, 0);
        tbl[2]  = mkv(1, 0, 0, 1, 1, 16'h6000, 16'h6000, 16'h0000, 2, 0, 16'h0057, 0);
        tbl[3]  = mkv(1, 0, 0, 1, 1, 16'h6001, 16'h6001, 16'h0000, 2, 0, 16'h0013, 0);
        tbl[4]  = mkv(0, 1, 0, 1, 0, 16'h4000, 16'h4000, 16'hABCD, 0, 2, 16'h4000, 0);
        tbl[5]  = mkv(1, 0, 0, 0, 1, 16'h4000, 16'h4000, 16'h0000, 4, 0, 16'h80CD, 0);
        tbl[6]  = mkv(1, 0, 1, 0, 1, 16'h3000, 16'h3000, 16'h0000, 5, 1, 16'h7777, 0);
        tbl[7]  = mkv(0, 1, 1, 0, 0, 16'h3000, 16'h3000, 16'h2468, 0, 2, 16'h3000, 0);
        tbl[8]  = mkv(1, 0, 0, 0, 1, 16'h5003, 16'h5003, 16'h0000, 6, 0, 16'h2468, TRAP_EN);
        tbl[9]  = mkv(0, 1, 0, 0, 0, 16'h2001, 16'h2001, 16'h9999, 0, 1, 16'h2001, TRAP_EN);
        tbl[10] = mkv(1, 0, 0, 0, 1, 16'h2000, 16'h2000, 16'h0000, 7, 3, TRAP_EN ? 16'h0000 : 16'h9999, 0);
        tbl[11] = mkv(1, 0, 0, 0, 1, 16'h6000, 16'h6000, 16'h0000, 1, 3, 16'h1357, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_result", wb_result, 16'h0);
        chk("rst_wb_fault", wb_fault, 1'b0);
        chk("rst_stall", mem_stall, 1'b0);
        chk("rst_req", {15'd0, dmem_read | dmem_write}, 16'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            model_exec(tbl[i], m_res, m_flt);
            run_vec(tbl[i], tbl[i].exp_res, tbl[i].exp_flt);
        end

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 6);
            v = mkv(0, 0, 0, 0, 1, 16'h8000 | 16'($urandom_range(0, 31)), 16'($urandom),
                    16'($urandom), 3'($urandom), $urandom_range(0, 3), 16'h0, 0);
            case (kind)
                1: v.rd = 1'b1;
                2: begin v.rd = 1'b1; v.byt = 1'b1; end
                3: begin v.wr = 1'b1; v.ldreg = 1'b0; end
                4: begin v.wr = 1'b1; v.byt = 1'b1; v.ldreg = 1'b0; end
                5: begin v.rd = 1'b1; v.ind = 1'b1; end
                6: begin v.wr = 1'b1; v.ind = 1'b1; v.ldreg = 1'b0; end
                default: ;
            endcase
            model_exec(v, m_res, m_flt);
            run_vec(v, m_res, m_flt);
            if ($urandom_range(0, 2) == 0) begin
                dmem_resp = 1'b1;
                @(posedge clk); #1;
                dmem_resp = 1'b0;
                chk("gap_wb_valid", wb_valid, 1'b0);
                chk("gap_stall", mem_stall, 1'b0);
            end
        end

        // Watchdog: LDW that never gets a response.
        mem_valid = 1'b1; mem_address = 16'h1000; mem_read_en = 1'b1; mem_write_en = 1'b0;
        mem_indirect = 1'b0; mem_byte = 1'b0; mem_load_reg = 1'b1; mem_drid = 3'd5;
        @(posedge clk); #1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("wd_read_held", dmem_read, 1'b1);
            chk("wd_stall", mem_stall, 1'b1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("wd_read_dropped", dmem_read, 1'b0);
        chk("wd_done_stall", mem_stall, 1'b0);
        @(posedge clk); #1;
        mem_valid = 1'b0;
        chk("wd_wb_valid", wb_valid, 1'b1);
        chk("wd_wb_fault", wb_fault, 1'b1);
        chk("wd_wb_load_reg", wb_load_reg, 1'b0);
        chk("wd_wb_drid", wb_drid, 3'd5);

        v = mkv(0, 0, 0, 0, 1, 16'h0000, 16'hBEEF, 16'h0000, 6, 0, 16'hBEEF, 0);
        run_vec(v, 16'hBEEF, 1'b0);

        // Reset in the middle of a store abandons it.
        mem_valid = 1'b1; mem_address = 16'h0100; mem_srcdata = 16'h5555; mem_read_en = 1'b0;
        mem_write_en = 1'b1; mem_byte = 1'b0; mem_indirect = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_write", dmem_write, 1'b1);
        mem_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_write", dmem_write, 1'b0);
        chk("arst_read", dmem_read, 1'b0);
        chk("arst_stall", mem_stall, 1'b0);
        chk("arst_wb_valid", wb_valid, 1'b0);
        chk("arst_wb_result", wb_result, 16'h0);
        chk("arst_wb_drid", wb_drid, 3'd0);
        chk("arst_wb_load_reg", wb_load_reg, 1'b0);
        chk("arst_wb_npc", wb_npc, 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_no_write", dmem_write, 1'b0);
        end
        chk("post_rst_mem", cache_rd(16'h0100), 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
